// File: rtl/axi4l_param_bank_if.sv
// AXI4-Lite slave bus bundle for the parameter bank.
// Master drives requests, slave returns readies and responses.
interface axi4l_param_bank_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [2:0]        s_axi_awprot;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [2:0]        s_axi_arprot;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/axi4l_param_bank.sv
// AXI4-Lite parameter bank: shadow/active RW words with atomic
// commit via a control word, plus read-only status words.
module axi4l_param_bank #(
  parameter int          ADDR_W  = 8,
  parameter int          N_RW    = 24,
  parameter int          N_RO    = 8,
  parameter logic [31:0] RST_VAL = '0
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  axi4l_param_bank_if.slave   s_axi,
  output logic [N_RW*32-1:0]  params,
  output logic                params_update,
  output logic [30:0]         ctrl_evt,
  input  logic [N_RO*32-1:0]  status_in
);
  localparam int IW = ADDR_W - 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          aw_held;
  logic          w_held;
  logic [IW-1:0] aw_idx_q;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          rvalid;
  logic [1:0]    rresp;
  logic [31:0]   rdata;
  logic [31:0]   shadow [N_RW];
  logic [31:0]   active [N_RW];

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic [IW-1:0] wi;
  logic [31:0]   wd;
  logic [3:0]    ws;
  logic [31:0]   wk;
  logic [31:0]   rk;
  logic          wr_exec;
  logic          wr_rw;
  logic          wr_ctrl;
  logic          commit;
  logic [31:0]   rd_data;
  logic [1:0]    rd_resp;
  logic          unused;

  assign unused = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                    s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  assign s_axi.s_axi_awready = s_axi_aresetn & ~aw_held & ~bvalid;
  assign s_axi.s_axi_wready  = s_axi_aresetn & ~w_held & ~bvalid;
  assign s_axi.s_axi_arready = s_axi_aresetn & ~rvalid;
  assign s_axi.s_axi_bvalid  = bvalid;
  assign s_axi.s_axi_bresp   = bresp;
  assign s_axi.s_axi_rvalid  = rvalid;
  assign s_axi.s_axi_rresp   = rresp;
  assign s_axi.s_axi_rdata   = rdata;

  assign aw_hs = s_axi.s_axi_awvalid & s_axi.s_axi_awready;
  assign w_hs  = s_axi.s_axi_wvalid & s_axi.s_axi_wready;
  assign ar_hs = s_axi.s_axi_arvalid & s_axi.s_axi_arready;

  // Held values win; otherwise the live handshake feeds the write.
  assign wi = aw_held ? aw_idx_q : s_axi.s_axi_awaddr[ADDR_W-1:2];
  assign wd = w_held ? w_data_q : s_axi.s_axi_wdata;
  assign ws = w_held ? w_strb_q : s_axi.s_axi_wstrb;

  assign wr_exec = (aw_held | aw_hs) & (w_held | w_hs);
  assign wk      = 32'(wi);
  assign wr_rw   = wk < N_RW;
  assign wr_ctrl = wk == N_RW;
  assign commit  = wr_exec & wr_ctrl & ws[0] & wd[0];

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      bvalid        <= 1'b0;
      bresp         <= OKAY;
      params_update <= 1'b0;
      ctrl_evt      <= '0;
    end else begin
      params_update <= commit;
      ctrl_evt <= (wr_exec & wr_ctrl & ws[0]) ? wd[31:1] : '0;
      if (wr_exec) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (wr_rw | wr_ctrl) ? OKAY : SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= wi;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.s_axi_wdata;
          w_strb_q <= s_axi.s_axi_wstrb;
        end
        if (bvalid & s_axi.s_axi_bready)
          bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      for (int k = 0; k < N_RW; k++) begin
        shadow[k] <= RST_VAL;
        active[k] <= RST_VAL;
      end
    end else begin
      for (int k = 0; k < N_RW; k++) begin
        if (wr_exec & wr_rw & (wk == 32'(k)))
          for (int j = 0; j < 4; j++)
            if (ws[j])
              shadow[k][8*j +: 8] <= wd[8*j +: 8];
        // Whole-set copy so downstream never sees a torn update.
        if (commit)
          active[k] <= shadow[k];
      end
    end
  end

  assign rk = 32'(s_axi.s_axi_araddr[ADDR_W-1:2]);

  always_comb begin
    rd_data = '0;
    rd_resp = SLVERR;
    if (rk <= N_RW + N_RO)
      rd_resp = OKAY;
    for (int k = 0; k < N_RW; k++)
      if (rk == 32'(k))
        rd_data = shadow[k];
    for (int k = 0; k < N_RO; k++)
      if (rk == 32'(N_RW + 1 + k))
        rd_data = status_in[32*k +: 32];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_resp;
    end else if (rvalid & s_axi.s_axi_rready) begin
      rvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_params
    assign params[32*g +: 32] = active[g];
  end
endmodule

// File: tb/tb_axi4l_param_bank.sv
// Scoreboard bench for axi4l_param_bank: directed AXI-Lite traffic,
// expected B/R responses queued and checked by a monitor.
module tb_axi4l_param_bank;
  localparam int ADDR_W = 8;
  localparam int N_RW   = 24;
  localparam int N_RO   = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi4l_param_bank_if #(.ADDR_W(ADDR_W)) bus ();

  logic [N_RW*32-1:0] params;
  logic               params_update;
  logic [30:0]        ctrl_evt;
  logic [N_RO*32-1:0] status_in;

  axi4l_param_bank #(
    .ADDR_W (ADDR_W),
    .N_RW   (N_RW),
    .N_RO   (N_RO),
    .RST_VAL(32'h0)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rstn),
    .s_axi        (bus),
    .params       (params),
    .params_update(params_update),
    .ctrl_evt     (ctrl_evt),
    .status_in    (status_in)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  always @(negedge clk) begin : mon
    logic [1:0]  eb;
    logic [33:0] er;
    if (bus.s_axi_bvalid && bus.s_axi_bready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected got=%b", bus.s_axi_bresp);
      end else begin
        eb = bq.pop_front();
        if (bus.s_axi_bresp !== eb) begin
          errors++;
          $display("FAIL bresp got=%b exp=%b", bus.s_axi_bresp, eb);
        end
      end
    end
    if (bus.s_axi_rvalid && bus.s_axi_rready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected got=%h", bus.s_axi_rdata);
      end else begin
        er = rq.pop_front();
        if ({bus.s_axi_rresp, bus.s_axi_rdata} !== er) begin
          errors++;
          $display("FAIL rdata got=%b/%h exp=%b/%h", bus.s_axi_rresp,
                   bus.s_axi_rdata, er[33:32], er[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_go(input logic [7:0] a);
    bus.s_axi_awaddr  = a;
    bus.s_axi_awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_axi_awready) begin
        tick();
        bus.s_axi_awvalid = 1'b0;
        return;
      end
      tick();
    end
    bus.s_axi_awvalid = 1'b0;
    tmo("aw_hs");
  endtask

  task automatic w_go(input logic [31:0] d, input logic [3:0] s);
    bus.s_axi_wdata  = d;
    bus.s_axi_wstrb  = s;
    bus.s_axi_wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_axi_wready) begin
        tick();
        bus.s_axi_wvalid = 1'b0;
        return;
      end
      tick();
    end
    bus.s_axi_wvalid = 1'b0;
    tmo("w_hs");
  endtask

  task automatic ar_go(input logic [7:0] a);
    bus.s_axi_araddr  = a;
    bus.s_axi_arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_axi_arready) begin
        tick();
        bus.s_axi_arvalid = 1'b0;
        return;
      end
      tick();
    end
    bus.s_axi_arvalid = 1'b0;
    tmo("ar_hs");
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] resp);
    bq.push_back(resp);
    fork
      aw_go(a);
      w_go(d, s);
    join
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] d,
                    input logic [1:0] resp);
    rq.push_back({resp, d});
    ar_go(a);
  endtask

  task automatic wait_b();
    for (int n = 0; n < 50; n++) begin
      if (bq.size() == 0) return;
      tick();
    end
    tmo("b_wait");
    bq.delete();
  endtask

  task automatic wait_r();
    for (int n = 0; n < 50; n++) begin
      if (rq.size() == 0) return;
      tick();
    end
    tmo("r_wait");
    rq.delete();
  endtask

  initial begin
    bus.s_axi_awaddr  = '0;
    bus.s_axi_awprot  = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready  = 1'b1;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arprot  = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b1;
    status_in = '0;

    repeat (3) tick();
    chk("rst_awready", 32'(bus.s_axi_awready), 0);
    chk("rst_wready",  32'(bus.s_axi_wready), 0);
    chk("rst_arready", 32'(bus.s_axi_arready), 0);
    chk("rst_bvalid",  32'(bus.s_axi_bvalid), 0);
    chk("rst_rvalid",  32'(bus.s_axi_rvalid), 0);
    chk("rst_params",  32'(params != '0), 0);
    rstn = 1'b1;
    tick();

    // AW two cycles ahead of W
    bq.push_back(2'b00);
    aw_go(8'd12);
    repeat (2) tick();
    w_go(32'h1234_5678, 4'hF);
    chk("b_latency", 32'(bus.s_axi_bvalid), 1);
    wait_b();
    rd(8'd12, 32'h1234_5678, 2'b00);
    wait_r();
    chk("w3_not_active", params[127:96], 32'h0);

    // Commit
    wr(8'd96, 32'h0000_0001, 4'hF, 2'b00);
    chk("commit_pulse", 32'(params_update), 1);
    chk("commit_w3", params[127:96], 32'h1234_5678);
    chk("commit_evt", {1'b0, ctrl_evt}, 32'h0);
    tick();
    chk("pulse_width", 32'(params_update), 0);
    wait_b();

    // Byte strobes
    wr(8'd0, 32'hFFFF_FFFF, 4'b0101, 2'b00);
    wait_b();
    rd(8'd0, 32'h00FF_00FF, 2'b00);
    wait_r();
    chk("w0_not_active", params[31:0], 32'h0);

    // Status, CTRL read and unmapped
    status_in[95:64] = 32'hCAFE_0002;
    rd(8'd108, 32'hCAFE_0002, 2'b00);
    wait_r();
    rd(8'd96, 32'h0, 2'b00);
    wait_r();
    rd(8'd252, 32'h0, 2'b10);
    wait_r();
    wr(8'd252, 32'hDEAD_BEEF, 4'hF, 2'b10);
    wait_b();
    wr(8'd104, 32'hDEAD_BEEF, 4'hF, 2'b10);
    wait_b();
    rd(8'd12, 32'h1234_5678, 2'b00);
    wait_r();
    chk("unmapped_no_commit", 32'(params_update), 0);

    // ctrl_evt only, then consecutive commits
    wr(8'd96, 32'h8000_0002, 4'h1, 2'b00);
    chk("evt_bits", {1'b0, ctrl_evt}, 32'h4000_0001);
    chk("evt_no_commit", 32'(params_update), 0);
    wait_b();
    wr(8'd96, 32'h0000_0001, 4'hE, 2'b00);
    chk("strb0_off_pulse", 32'(params_update), 0);
    chk("strb0_off_evt", {1'b0, ctrl_evt}, 32'h0);
    wait_b();
    wr(8'd96, 32'h0000_0003, 4'hF, 2'b00);
    chk("commit2_pulse", 32'(params_update), 1);
    chk("commit2_evt", {1'b0, ctrl_evt}, 32'h1);
    chk("commit2_w0", params[31:0], 32'h00FF_00FF);
    wait_b();
    wr(8'd96, 32'h0000_0001, 4'h1, 2'b00);
    chk("commit3_pulse", 32'(params_update), 1);
    wait_b();

    // Backpressure on B
    bus.s_axi_bready = 1'b0;
    wr(8'd20, 32'hA5A5_A5A5, 4'hF, 2'b00);
    bus.s_axi_awaddr  = 8'd24;
    bus.s_axi_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_awready", 32'(bus.s_axi_awready), 0);
      chk("bp_wready", 32'(bus.s_axi_wready), 0);
      chk("bp_bvalid", 32'(bus.s_axi_bvalid), 1);
      tick();
    end
    bus.s_axi_bready = 1'b1;
    bq.push_back(2'b00);
    aw_go(8'd24);
    w_go(32'h0000_0066, 4'hF);
    wait_b();
    rd(8'd24, 32'h0000_0066, 2'b00);
    wait_r();
    rd(8'd20, 32'hA5A5_A5A5, 2'b00);
    wait_r();

    // Same-cycle AW+W+AR returns pre-write data
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h1234_5678});
    fork
      aw_go(8'd12);
      w_go(32'h1111_2222, 4'hF);
      ar_go(8'd12);
    join
    wait_b();
    wait_r();
    rd(8'd12, 32'h1111_2222, 2'b00);
    wait_r();

    // Reset with AW held drops the write
    aw_go(8'd28);
    rstn = 1'b0;
    tick();
    chk("rst_wready_low", 32'(bus.s_axi_wready), 0);
    chk("rst_arready_low", 32'(bus.s_axi_arready), 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_bvalid", 32'(bus.s_axi_bvalid), 0);
    end
    chk("rst2_params", 32'(params != '0), 0);
    rd(8'd12, 32'h0, 2'b00);
    wait_r();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
